// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
// Optional feature macro: SERIAL_ADD_OVF_EN (signed overflow flag).
package serial_add_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit counter must reach WIDTH-1 without wrapping.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle between a requester and serial_adder_ctrl.
// Optional feature macro: SERIAL_ADD_OVF_EN (drives overflow).
interface serial_adder_ctrl_if
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             start;
    logic             sub;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;

    modport master (
        output start, sub, op_a, op_b,
        input  busy, done, result, cout, overflow
    );

    modport slave (
        input  start, sub, op_a, op_b,
        output busy, done, result, cout, overflow
    );

endinterface

// File: rtl/serial_adder_ctrl_fa.sv
// Single-bit combinational full adder used by the serial datapath.
// Optional feature macro: SERIAL_ADD_OVF_EN (not used here).
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller, LSB first, one bit per cycle.
// Optional feature macro: SERIAL_ADD_OVF_EN (registered signed overflow).
module serial_adder_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input logic              clk,
    input logic              rst,
    serial_adder_ctrl_if.slave bus
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam int IDX_W = CNT_W - 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_sub;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_res;
    logic             r_cout;
    logic             r_busy;
    logic             r_done;

    logic [IDX_W-1:0] w_idx;
    logic             w_a_bit;
    logic             w_b_bit;
    logic             w_s;
    logic             w_co;

    // Operands stay frozen; the counter selects the current bit.
    assign w_idx   = r_cnt[IDX_W-1:0];
    assign w_a_bit = r_a[w_idx];
    assign w_b_bit = r_b[w_idx] ^ r_sub;

    fa_cell u_fa (
        .a  (w_a_bit),
        .b  (w_b_bit),
        .ci (r_carry),
        .s  (w_s),
        .co (w_co)
    );

`ifdef SERIAL_ADD_OVF_EN
    logic r_ovf;

    // Carry into MSB is the live carry during the last RUN cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ovf <= 1'b0;
        end else if (r_state == RUN && r_cnt == CNT_LAST) begin
            r_ovf <= r_carry ^ w_co;
        end
    end

    assign bus.overflow = r_ovf;
`else
    assign bus.overflow = 1'b0;
`endif

    // Control FSM plus serial datapath state and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sub   <= 1'b0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_res   <= '0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_a     <= bus.op_a;
                        r_b     <= bus.op_b;
                        r_sub   <= bus.sub;
                        r_carry <= bus.sub;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_res   <= {w_s, r_res[WIDTH-1:1]};
                    r_carry <= w_co;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_LAST) begin
                        r_cout  <= w_co;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_res;
    assign bus.cout   = r_cout;

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits; the module SHALL support WIDTH >= 2.
REQ-002 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request to begin an operation.
REQ-005 sub  input  1  0 = A+B, 1 = A-B; sampled with start.
REQ-006 op_a  input  WIDTH  operand A; sampled with start.
REQ-007 op_b  input  WIDTH  operand B; sampled with start.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  single-cycle pulse; result is valid.
REQ-010 result  output  WIDTH  sum or difference.
REQ-011 cout  output  1  final carry out; for subtraction, 1 means no borrow.
REQ-012 overflow  output  1  signed overflow flag (see Configuration).

Function
REQ-013 The module SHALL compute the result bit-serially, LSB first, through one 1-bit full-adder cell, one bit per cycle.
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 IDLE: if start=1 at an edge, the module SHALL capture op_a, op_b and sub, preload carry with sub and clear the bit counter, then go to RUN.
REQ-016 RUN: each cycle SHALL add a_bit, b_bit XOR sub and carry; shift the sum into the MSB of the result shift register; update carry; and increment the counter.
REQ-017 RUN SHALL go to DONE after exactly WIDTH cycles, i.e. the edge at which counter = WIDTH-1.
REQ-018 DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-019 busy SHALL be 1 in RUN and DONE, and 0 in IDLE.
REQ-020 Latency: done SHALL be high in the (WIDTH+1)th cycle after the start-accept edge.
REQ-021 start SHALL be ignored in RUN and DONE; captured operands SHALL NOT change mid-operation.
REQ-022 result, cout and overflow SHALL hold their values from DONE until the next accepted start.
REQ-023 Arithmetic SHALL be modulo 2^WIDTH; cout SHALL equal the carry out of bit WIDTH-1.
REQ-024 The counter width SHALL be $clog2(WIDTH)+1 bits, with no wrap-around before the terminal count.
REQ-025 start held high continuously SHALL cause back-to-back operations: accept in IDLE, with one idle cycle between done and the next accept.

Reset
REQ-026 When rst=0 at an edge, the module SHALL enter IDLE and clear busy, done, result, cout, overflow, carry and counter to 0, including when the reset falls in RUN or DONE.
REQ-027 An operation interrupted by reset SHALL produce no done pulse.
REQ-028 start SHALL be ignored on any edge where rst=0.

Configuration
REQ-029 Macro SERIAL_ADD_OVF_EN defined: overflow SHALL be carry-into-MSB XOR carry-out-of-MSB, registered at the last RUN cycle.
REQ-030 Macro undefined: overflow SHALL be tied to 0, and no carry-into-MSB register SHALL exist.

Structure
REQ-031 Package serial_add_pkg SHALL hold the state enum (IDLE/RUN/DONE) and the default-width constant.
REQ-032 Sub-module fa_cell (inputs a, b, ci; outputs s, co) SHALL be the single combinational full adder, instantiated once.

Verification (WIDTH=8)
REQ-033 0x0F+0x01, sub=0: result=0x10, cout=0, done 9 cycles after accept, busy high for 9 cycles.
REQ-034 0xFF+0x01: result=0x00, cout=1; overflow=0 with the macro.
REQ-035 0x05-0x07, sub=1: result=0xFE, cout=0; overflow=0.
REQ-036 0x7F+0x01: result=0x80, cout=0; overflow=1 with the macro defined, 0 without it.
REQ-037 rst=0 at RUN cycle 3, then a new start: no done for the first operation; the second operation completes correctly; start pulses during busy are ignored with no change to operands or latency.
